// File: rtl/fifo_rr_read_scheduler_if.sv
// Signal bundle between the source FIFOs, the round-robin read scheduler and the
// downstream stage. The master modport is the scheduler's view of the bundle.
interface fifo_rr_read_scheduler_if #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2,
    parameter int DATA_WIDTH = 65
);
    logic                            stall;
    logic [NUM_PORTS-1:0]            empty;
    logic [NUM_PORTS-1:0]            fifo_valid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data;
    logic [NUM_PORTS-1:0]            read_en;
    logic [NUM_PORTS-1:0]            grant;
    logic [DATA_WIDTH-1:0]           fwd_data;
    logic [PORT_WIDTH-1:0]           fwd_port;
    logic                            fwd_valid;
    logic                            err;

    modport master (
        input  stall, empty, fifo_valid, fifo_data,
        output read_en, grant, fwd_data, fwd_port, fwd_valid, err
    );

    modport slave (
        output stall, empty, fifo_valid, fifo_data,
        input  read_en, grant, fwd_data, fwd_port, fwd_valid, err
    );
endinterface

// File: rtl/fifo_rr_read_scheduler.sv
// Round-robin burst read scheduler: drains NUM_PORTS one-cycle-latency FIFOs into a single
// downstream stage, tagging each forwarded word with its source port.
module fifo_rr_read_scheduler #(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_WIDTH = 2,
    parameter int DATA_WIDTH = 65,
    parameter int BURST_LEN  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_rr_read_scheduler_if.master bus
);
    localparam int CNT_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [PORT_WIDTH-1:0] PORT_LAST = PORT_WIDTH'(NUM_PORTS - 1);
    localparam logic [NUM_PORTS-1:0]  VEC_ONE   = NUM_PORTS'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_next;
    logic [PORT_WIDTH-1:0] gnt_idx, gnt_idx_next;
    logic [PORT_WIDTH-1:0] last_grant, last_grant_next;
    logic [CNT_WIDTH-1:0]  cnt, cnt_next;
    logic                  issue;

    logic                  pick_found;
    logic [PORT_WIDTH-1:0] pick_idx;
    int                    scan;
    logic [PORT_WIDTH-1:0] scan_port;

    logic [PORT_WIDTH-1:0] iss_port;
    logic                  iss_vld;
    logic [NUM_PORTS-1:0]  expect_valid;
    logic                  multi_valid;
    logic                  stray_valid;
    logic                  missing_valid;

    // Wrap by subtraction so NUM_PORTS need not be a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan       = 0;
        scan_port  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan = int'(last_grant) + k;
            if (scan >= NUM_PORTS) begin
                scan = scan - NUM_PORTS;
            end
            scan_port = PORT_WIDTH'(scan);
            if (!pick_found && !bus.empty[scan_port]) begin
                pick_found = 1'b1;
                pick_idx   = scan_port;
            end
        end
    end

    always_comb begin
        state_next      = state;
        gnt_idx_next    = gnt_idx;
        last_grant_next = last_grant;
        cnt_next        = cnt;
        issue           = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next   = BURST;
                    gnt_idx_next = pick_idx;
                    cnt_next     = '0;
                end
            end
            BURST: begin
                if (bus.empty[gnt_idx]) begin
                    state_next      = IDLE;
                    last_grant_next = gnt_idx;
                end else if (!bus.stall) begin
                    issue = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_next      = IDLE;
                        last_grant_next = gnt_idx;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.grant   = '0;
        bus.read_en = '0;
        if (state == BURST) begin
            bus.grant[gnt_idx] = 1'b1;
        end
        if (issue) begin
            bus.read_en[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt_idx    <= '0;
            last_grant <= PORT_LAST;
            cnt        <= '0;
        end else begin
            state      <= state_next;
            gnt_idx    <= gnt_idx_next;
            last_grant <= last_grant_next;
            cnt        <= cnt_next;
        end
    end

    // Only the port read last cycle may answer, and it must answer exactly then.
    always_comb begin
        expect_valid = '0;
        if (iss_vld) begin
            expect_valid[iss_port] = 1'b1;
        end
    end

    assign multi_valid   = |(bus.fifo_valid & (bus.fifo_valid - VEC_ONE));
    assign stray_valid   = |(bus.fifo_valid & ~expect_valid);
    assign missing_valid = iss_vld & ~bus.fifo_valid[iss_port];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_port      <= '0;
            iss_vld       <= 1'b0;
            bus.fwd_data  <= '0;
            bus.fwd_port  <= '0;
            bus.fwd_valid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            iss_port <= gnt_idx;
            iss_vld  <= issue;
            if (iss_vld && bus.fifo_valid[iss_port]) begin
                bus.fwd_data  <= bus.fifo_data[int'(iss_port)*DATA_WIDTH +: DATA_WIDTH];
                bus.fwd_port  <= iss_port;
                bus.fwd_valid <= 1'b1;
            end else begin
                bus.fwd_valid <= 1'b0;
            end
            bus.err <= bus.err | multi_valid | stray_valid | missing_valid;
        end
    end
endmodule

// File: tb/tb_fifo_rr_read_scheduler.sv
// Bench for fifo_rr_read_scheduler: behavioural FIFO sources plus a rule-level model of
// grant order, burst limits, stall and the two-cycle return path.
module tb_fifo_rr_read_scheduler;
    localparam int NP    = 4;
    localparam int PW    = 2;
    localparam int DW    = 65;
    localparam int BL    = 4;
    localparam int DEPTH = 64;

    typedef struct {
        int            due;
        int            port;
        logic [DW-1:0] data;
    } fwd_t;

    logic clk;
    logic rst;

    fifo_rr_read_scheduler_if #(.NUM_PORTS(NP), .PORT_WIDTH(PW), .DATA_WIDTH(DW)) bus ();

    fifo_rr_read_scheduler #(
        .NUM_PORTS (NP),
        .PORT_WIDTH(PW),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem [NP][DEPTH];
    int            head [NP];
    int            tail [NP];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            cyc          = 0;
    int            m_grant, m_last, m_cnt;
    logic          m_err;
    fwd_t          exp_fwd [$];
    logic [DW-1:0] last_data;
    logic [PW-1:0] last_port;
    bit            check_fwd, inject, inj_now;
    int            reads_seen, fwd_seen, pushed, burst_reads;
    int            bursts [$];
    int            grant_log [$];
    logic [NP-1:0] prev_grant, last_re;
    int            stall_mode, stall_left;
    bit            stall_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        check_output(tag, 128'(obs), 128'(exp));
    endtask

    function automatic int onehot_to_int(input logic [NP-1:0] v);
        int r = -1;
        for (int i = 0; i < NP; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic bit fifos_busy();
        bit b = 0;
        for (int p = 0; p < NP; p++) if (tail[p] != head[p]) b = 1;
        return b;
    endfunction

    task automatic refresh_empty();
        for (int p = 0; p < NP; p++) bus.empty[p] = (tail[p] == head[p]);
    endtask

    task automatic load(input int p, input int n);
        logic [95:0] r;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            if (tail[p] - head[p] < DEPTH) begin
                mem[p][tail[p] % DEPTH] = r[DW-1:0];
                tail[p]++;
                pushed++;
            end
        end
        refresh_empty();
    endtask

    // Source FIFOs answer one cycle after an accepted read; also drives stall for the next cycle.
    task automatic update_fifos(input logic [NP-1:0] re);
        bus.fifo_valid = '0;
        for (int p = 0; p < NP; p++) begin
            if (re[p] && tail[p] != head[p]) begin
                bus.fifo_data[p*DW +: DW] = mem[p][head[p] % DEPTH];
                head[p]++;
                bus.fifo_valid[p] = 1'b1;
            end
        end
        if (inject) begin
            bus.fifo_valid = 4'b0101;
            inject  = 0;
            inj_now = 1;
        end
        refresh_empty();
        case (stall_mode)
            1: bus.stall = ($urandom_range(0, 3) == 0);
            2: begin
                if (!stall_done && reads_seen == 2) begin
                    stall_left = 3;
                    stall_done = 1;
                end
                bus.stall = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end
            default: bus.stall = 1'b0;
        endcase
    endtask

    task automatic check_cycle();
        logic [NP-1:0] exp_grant, exp_re;
        logic          exp_v;
        fwd_t          e;
        bit            found;
        int            idx;
        exp_grant = '0;
        if (m_grant >= 0) exp_grant = NP'(1) << m_grant;
        exp_re = '0;
        if (m_grant >= 0 && !bus.stall && !bus.empty[m_grant]) exp_re = exp_grant;
        check_output("grant", 128'(bus.grant), 128'(exp_grant));
        check_output("read_en", 128'(bus.read_en), 128'(exp_re));
        check_output("err", 128'(bus.err), 128'(m_err));
        exp_v = 1'b0;
        if (exp_fwd.size() > 0 && exp_fwd[0].due == cyc) begin
            e         = exp_fwd.pop_front();
            exp_v     = 1'b1;
            last_data = e.data;
            last_port = PW'(e.port);
        end
        if (check_fwd) begin
            check_output("fwd_valid", 128'(bus.fwd_valid), 128'(exp_v));
            check_output("fwd_data", 128'(bus.fwd_data), 128'(last_data));
            check_output("fwd_port", 128'(bus.fwd_port), 128'(last_port));
        end
        if (bus.read_en != '0) begin
            reads_seen++;
            burst_reads++;
        end
        if (bus.fwd_valid) fwd_seen++;
        if (bus.grant != '0 && prev_grant == '0) grant_log.push_back(onehot_to_int(bus.grant));
        if (bus.grant == '0 && prev_grant != '0) begin
            bursts.push_back(burst_reads);
            burst_reads = 0;
        end
        prev_grant = bus.grant;
        // Next-cycle expectation from the arbitration rules.
        if (m_grant < 0) begin
            found = 0;
            for (int k = 1; k <= NP; k++) begin
                idx = (m_last + k) % NP;
                if (!found && !bus.empty[idx]) begin
                    found   = 1;
                    m_grant = idx;
                    m_cnt   = 0;
                end
            end
        end else if (bus.empty[m_grant]) begin
            m_last  = m_grant;
            m_grant = -1;
        end else if (!bus.stall) begin
            exp_fwd.push_back('{due: cyc + 2, port: m_grant, data: mem[m_grant][head[m_grant] % DEPTH]});
            m_cnt++;
            if (m_cnt == BL) begin
                m_last  = m_grant;
                m_grant = -1;
            end
        end
        if (inj_now) begin
            m_err   = 1'b1;
            inj_now = 0;
        end
        cyc++;
    endtask

    task automatic tick();
        logic [NP-1:0] re;
        @(negedge clk);
        check_cycle();
        re      = bus.read_en;
        last_re = re;
        @(posedge clk);
        #1;
        update_fifos(re);
    endtask

    task automatic apply_stimulus_reset();
        rst         = 1'b1;
        m_grant     = -1;
        m_last      = NP - 1;
        m_cnt       = 0;
        m_err       = 1'b0;
        exp_fwd.delete();
        last_data   = '0;
        last_port   = '0;
        inject      = 0;
        inj_now     = 0;
        prev_grant  = '0;
        burst_reads = 0;
        #1;
        check_output("rst_grant", 128'(bus.grant), 128'(0));
        check_output("rst_read_en", 128'(bus.read_en), 128'(0));
        check_output("rst_fwd_valid", 128'(bus.fwd_valid), 128'(0));
        check_output("rst_fwd_data", 128'(bus.fwd_data), 128'(0));
        check_output("rst_fwd_port", 128'(bus.fwd_port), 128'(0));
        check_output("rst_err", 128'(bus.err), 128'(0));
        repeat (2) begin
            @(posedge clk);
            #1;
            update_fifos('0);
        end
        rst = 1'b0;
    endtask

    task automatic run_until_drained(input int max_cycles);
        int n = 0;
        while ((fifos_busy() || exp_fwd.size() != 0 || m_grant >= 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check_int("drain_timeout", int'(n < max_cycles), 1);
        repeat (3) tick();
    endtask

    initial begin
        int exp_p2 [3] = '{4, 4, 2};
        int exp_p3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_p4 [2] = '{4, 2};
        int n, p, first;
        logic [95:0] r;

        rst            = 1'b0;
        bus.stall      = 1'b0;
        bus.empty      = '1;
        bus.fifo_valid = '0;
        bus.fifo_data  = '0;
        for (int i = 0; i < NP; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        check_fwd  = 1;
        stall_mode = 0;
        stall_left = 0;
        stall_done = 0;
        pushed     = 0;
        last_re    = '0;
        #2;
        apply_stimulus_reset();

        // All sources empty: the scheduler must sit idle.
        reads_seen = 0;
        fwd_seen   = 0;
        repeat (10) tick();
        check_int("idle_reads", reads_seen, 0);
        check_int("idle_fwd", fwd_seen, 0);

        // Single busy port: bursts of 4, 4, 2.
        bursts.delete();
        fwd_seen = 0;
        load(2, 10);
        run_until_drained(100);
        check_int("p2_fwd_count", fwd_seen, 10);
        check_int("p2_burst_n", bursts.size(), 3);
        for (int i = 0; i < 3; i++) if (i < bursts.size()) check_int("p2_burst_len", bursts[i], exp_p2[i]);

        // All ports busy from reset: strict rotation starting at port 0.
        apply_stimulus_reset();
        bursts.delete();
        grant_log.delete();
        fwd_seen = 0;
        for (int i = 0; i < NP; i++) load(i, 8);
        run_until_drained(200);
        check_int("p3_fwd_count", fwd_seen, 32);
        check_int("p3_grant_n", grant_log.size(), 8);
        for (int i = 0; i < 8; i++) if (i < grant_log.size()) check_int("p3_grant_order", grant_log[i], exp_p3[i]);

        // Stall for three cycles after the second read of a port 1 burst.
        bursts.delete();
        reads_seen = 0;
        stall_done = 0;
        stall_left = 0;
        stall_mode = 2;
        load(1, 6);
        run_until_drained(100);
        stall_mode = 0;
        check_int("p4_burst_n", bursts.size(), 2);
        for (int i = 0; i < 2; i++) if (i < bursts.size()) check_int("p4_burst_len", bursts[i], exp_p4[i]);

        // Port 3 empties after one read, then arbitration wraps to port 0.
        bursts.delete();
        load(3, 1);
        run_until_drained(50);
        check_int("p5_burst_n", bursts.size(), 1);
        if (bursts.size() > 0) check_int("p5_burst_len", bursts[0], 1);
        grant_log.delete();
        load(0, 3);
        load(2, 3);
        run_until_drained(50);
        first = (grant_log.size() > 0) ? grant_log[0] : -1;
        check_int("p5_wrap_grant", first, 0);

        // Random traffic with random stall.
        stall_mode = 1;
        pushed     = 0;
        fwd_seen   = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, NP - 1);
                load(p, 1);
            end
            tick();
        end
        run_until_drained(2000);
        stall_mode = 0;
        check_int("rand_fwd_count", fwd_seen, pushed);

        // Protocol error injection, then reset in the middle of a burst with a read in flight.
        load(0, 12);
        load(2, 12);
        n = 0;
        while (bus.grant == '0 && n < 10) begin
            tick();
            n++;
        end
        check_int("p7_grant_wait", int'(n < 10), 1);
        tick();
        check_fwd = 0;
        inject    = 1;
        repeat (4) tick();
        check_output("p7_err_sticky", 128'(bus.err), 128'(1));
        n = 0;
        tick();
        while (last_re == '0 && n < 10) begin
            tick();
            n++;
        end
        check_int("p7_read_wait", int'(n < 10), 1);
        apply_stimulus_reset();
        check_fwd = 1;
        grant_log.delete();
        run_until_drained(300);
        first = (grant_log.size() > 0) ? grant_log[0] : -1;
        check_int("p7_first_grant", first, 0);

        r = '0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
